// File: rtl/if_fetch_queue.sv
// Fetch stage: issues instruction reads at the PC address and queues
// returned {pc,instr} pairs for decode, with redirect and drop handling.
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Clr_n,
    input  logic [31:0] PcAddr,
    output logic        StallF,
    input  logic        Flush,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic        IfValid,
    output logic [31:0] IfPc,
    output logic [31:0] IfInstr,
    input  logic        DecReady
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [31:0]   req_pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          pop;
    logic          push;
    logic          room;
    logic          issue;

    assign pop       = (count != '0) & DecReady & ~Flush;
    assign push      = (state == WAIT) & ImemAck & ~Flush;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign room      = count_nxt < CW'(DEPTH);
    assign rd_nxt    = rd_ptr + AW'(pop);

    // Gated by Clr_n so nothing is requested while reset is held.
    assign issue = Clr_n & ~Flush & room &
                   ((state == IDLE) | ((state == WAIT) & ImemAck));

    assign ImemReq  = issue;
    assign ImemAddr = PcAddr;
    assign StallF   = ~Clr_n | ~(issue | Flush);
    assign IfValid  = (count != '0);
    assign IfPc     = head_pc;
    assign IfInstr  = head_instr;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            req_pc <= '0;
        end else begin
            if (issue) req_pc <= PcAddr;
            if (Flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count_nxt;
                rd_ptr <= rd_nxt;
                if (push) wr_ptr <= wr_ptr + AW'(1);
            end
            unique case (state)
                IDLE: if (issue) state <= WAIT;
                WAIT: begin
                    if (Flush)        state <= ImemAck ? IDLE : DROP;
                    else if (ImemAck) state <= issue ? WAIT : IDLE;
                end
                DROP: if (ImemAck) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= req_pc;
            mem_instr[wr_ptr] <= ImemRdata;
        end
    end

    // Head is registered so it holds its last value once the queue drains.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            head_pc    <= '0;
            head_instr <= '0;
        end else if (!Flush && count_nxt != '0) begin
            if (push && count_nxt == CW'(1)) begin
                head_pc    <= req_pc;
                head_instr <= ImemRdata;
            end else begin
                head_pc    <= mem_pc[rd_nxt];
                head_instr <= mem_instr[rd_nxt];
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: PC and variable-latency memory models drive
// the fetch stage; directed scenarios plus a random run with a scoreboard.
module tb_if_fetch_queue;

    logic        Clk = 1'b0;
    logic        Clr_n;
    logic [31:0] PcAddr;
    logic        StallF;
    logic        Flush;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic        IfValid;
    logic [31:0] IfPc;
    logic [31:0] IfInstr;
    logic        DecReady;

    if_fetch_queue #(.DEPTH(2)) dut (
        .Clk(Clk), .Clr_n(Clr_n), .PcAddr(PcAddr), .StallF(StallF),
        .Flush(Flush), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemRdata(ImemRdata), .IfValid(IfValid),
        .IfPc(IfPc), .IfInstr(IfInstr), .DecReady(DecReady)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail = 0;

    // environment model state
    logic [31:0] pc_m, rst_pc, target, paddr;
    logic        pend;
    int          wt, lat;

    // values sampled on the falling edge of the cycle just completed
    logic        s_req, s_stall, s_valid, s_ack, s_flush, s_dec, s_rst, s_pend;
    logic [31:0] s_addr, s_pc, s_instr, s_pcaddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] r;
        r = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        return r;
    endfunction

    // One clock: sample outputs, then advance PC and memory models.
    task automatic tick();
        @(negedge Clk);
        s_req = ImemReq;   s_addr = ImemAddr;  s_stall = StallF;
        s_valid = IfValid; s_pc = IfPc;        s_instr = IfInstr;
        s_ack = ImemAck;   s_flush = Flush;    s_dec = DecReady;
        s_rst = Clr_n;     s_pcaddr = PcAddr;  s_pend = pend;
        @(posedge Clk);
        #1;
        if (s_ack) pend = 1'b0;
        if (s_req) begin
            pend = 1'b1; paddr = s_addr; wt = lat - 1;
        end else if (pend && wt > 0) begin
            wt = wt - 1;
        end
        ImemAck = pend && (wt == 0);
        ImemRdata = ImemAck ? mem_word(paddr) : $urandom;
        if (!s_rst)       pc_m = rst_pc;
        else if (s_flush) pc_m = target;
        else if (!s_stall) pc_m = pc_m + 32'd4;
        PcAddr = pc_m;
    endtask

    task automatic do_reset(input logic [31:0] rp, input int l);
        rst_pc = rp; lat = l;
        Clr_n = 1'b0; Flush = 1'b0; DecReady = 1'b0;
        repeat (4) tick();
        Clr_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_pc = 32'h3000; lat = 1;
        Clr_n = 1'b0; Flush = 1'b0; DecReady = 1'b0;
        tick(); tick();
        n_checks++; if (s_req !== 1'b0)
            begin n_fail++; $display("FAIL rst_req got %b want 0", s_req); end
        n_checks++; if (s_stall !== 1'b1)
            begin n_fail++; $display("FAIL rst_stall got %b want 1", s_stall); end
        n_checks++; if (s_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_valid got %b want 0", s_valid); end
        n_checks++; if (s_pc !== 32'h0 || s_instr !== 32'h0)
            begin n_fail++; $display("FAIL rst_head got %h/%h want 0/0", s_pc, s_instr); end
        Clr_n = 1'b1; DecReady = 1'b1;
        tick();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h3000)
            begin n_fail++; $display("FAIL rst_first_req got %b@%h want 1@3000", s_req, s_addr); end
        n_checks++; if (s_stall !== 1'b0)
            begin n_fail++; $display("FAIL rst_first_stall got %b want 0", s_stall); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(32'h3000, 1);
        DecReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++; if (s_req !== 1'b1)
                begin n_fail++; $display("FAIL stream_req c%0d got %b want 1", k, s_req); end
            if (k >= 2) begin
                e = 32'h3000 + 32'(4 * (k - 2));
                n_checks++; if (s_valid !== 1'b1 || s_pc !== e)
                    begin n_fail++; $display("FAIL stream_pc c%0d got %b/%h want 1/%h", k, s_valid, s_pc, e); end
                n_checks++; if (s_instr !== mem_word(e))
                    begin n_fail++; $display("FAIL stream_instr c%0d got %h want %h", k, s_instr, mem_word(e)); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(32'h3000, 1);
        DecReady = 1'b0;
        tick(); tick();
        for (int k = 2; k < 4; k++) begin
            tick();
            n_checks++; if (s_req !== 1'b0 || s_stall !== 1'b1)
                begin n_fail++; $display("FAIL full_hold c%0d got req %b stall %b want 0 1", k, s_req, s_stall); end
            n_checks++; if (s_pcaddr !== 32'h3008 || s_pc !== 32'h3000)
                begin n_fail++; $display("FAIL full_pc c%0d got %h/%h want 3008/3000", k, s_pcaddr, s_pc); end
        end
        DecReady = 1'b1;
        tick();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h3008)
            begin n_fail++; $display("FAIL full_resume got %b@%h want 1@3008", s_req, s_addr); end
        tick();
        n_checks++; if (s_pc !== 32'h3004)
            begin n_fail++; $display("FAIL full_pop1 got %h want 3004", s_pc); end
        tick();
        n_checks++; if (s_pc !== 32'h3008 || s_instr !== mem_word(32'h3008))
            begin n_fail++; $display("FAIL full_pop2 got %h/%h want 3008", s_pc, s_instr); end
    endtask

    task automatic test_flush_wait();
        int n;
        do_reset(32'h4000, 3);
        DecReady = 1'b1;
        tick();
        Flush = 1'b1; target = 32'h4180;
        tick();
        n_checks++; if (s_stall !== 1'b0 || s_req !== 1'b0)
            begin n_fail++; $display("FAIL fw_flush got stall %b req %b want 0 0", s_stall, s_req); end
        Flush = 1'b0;
        tick(); tick();
        n_checks++; if (s_stall !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0)
            begin n_fail++; $display("FAIL fw_drop got stall %b req %b valid %b want 1 0 0", s_stall, s_req, s_valid); end
        tick();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h4180)
            begin n_fail++; $display("FAIL fw_reissue got %b@%h want 1@4180", s_req, s_addr); end
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 10);
        n_checks++; if (s_valid !== 1'b1 || s_pc !== 32'h4180 || s_instr !== mem_word(32'h4180))
            begin n_fail++; $display("FAIL fw_first got %b %h/%h want 1 4180", s_valid, s_pc, s_instr); end
    endtask

    task automatic test_flush_ack();
        int n;
        do_reset(32'h5000, 2);
        DecReady = 1'b0;
        repeat (4) tick();
        Flush = 1'b1; DecReady = 1'b1; target = 32'h5200;
        tick();
        n_checks++; if (s_valid !== 1'b1 || s_req !== 1'b0 || s_stall !== 1'b0)
            begin n_fail++; $display("FAIL fa_flush got valid %b req %b stall %b want 1 0 0", s_valid, s_req, s_stall); end
        Flush = 1'b0;
        tick();
        n_checks++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h5200)
            begin n_fail++; $display("FAIL fa_after got valid %b req %b@%h want 0 1@5200", s_valid, s_req, s_addr); end
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 10);
        n_checks++; if (s_valid !== 1'b1 || s_pc !== 32'h5200)
            begin n_fail++; $display("FAIL fa_first got %b %h want 1 5200", s_valid, s_pc); end
    endtask

    task automatic test_reset_wait();
        int n;
        do_reset(32'h6000, 3);
        DecReady = 1'b0;
        repeat (4) tick();
        n_checks++; if (IfValid !== 1'b1)
            begin n_fail++; $display("FAIL rw_pre got valid %b want 1", IfValid); end
        rst_pc = 32'h6100;
        Clr_n = 1'b0;
        #1;
        n_checks++; if (IfValid !== 1'b0 || ImemReq !== 1'b0 || StallF !== 1'b1)
            begin n_fail++; $display("FAIL rw_async got valid %b req %b stall %b want 0 0 1", IfValid, ImemReq, StallF); end
        tick(); tick();
        Clr_n = 1'b1;
        tick();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h6100 || s_valid !== 1'b0)
            begin n_fail++; $display("FAIL rw_restart got req %b@%h valid %b want 1@6100 0", s_req, s_addr, s_valid); end
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 10);
        n_checks++; if (n !== 4 || s_pc !== 32'h6100 || s_instr !== mem_word(32'h6100))
            begin n_fail++; $display("FAIL rw_first got %0d cycles %h/%h want 4 6100", n, s_pc, s_instr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int pops = 0;
        do_reset(32'h8000, 2);
        exp_pc = 32'h8000;
        for (int k = 0; k < 2000; k++) begin
            lat = $urandom_range(1, 3);
            DecReady = ($urandom_range(0, 99) < 70);
            Flush = ($urandom_range(0, 99) < 3);
            target = $urandom & 32'hFFFF_FFFC;
            tick();
            if (s_req && (s_addr !== s_pcaddr)) begin
                n_checks++; n_fail++;
                $display("FAIL rnd_addr got %h want %h", s_addr, s_pcaddr);
            end
            n_checks++; if (s_stall !== !(s_req | s_flush))
                begin n_fail++; $display("FAIL rnd_stall got %b req %b flush %b", s_stall, s_req, s_flush); end
            n_checks++; if (s_req && s_pend && !s_ack)
                begin n_fail++; $display("FAIL rnd_outstanding got req with read pending"); end
            if (s_flush) begin
                exp_pc = target;
            end else if (s_valid && s_dec) begin
                pops++;
                n_checks++; if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc))
                    begin n_fail++; $display("FAIL rnd_pop got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
        end
        Flush = 1'b0;
        n_checks++; if (pops < 200)
            begin n_fail++; $display("FAIL rnd_progress got %0d pops want >=200", pops); end
    endtask

    initial begin
        Clr_n = 1'b1; Flush = 1'b0; DecReady = 1'b0;
        PcAddr = 32'h3000; ImemAck = 1'b0; ImemRdata = '0;
        pc_m = 32'h3000; rst_pc = 32'h3000; target = '0; paddr = '0;
        pend = 1'b0; wt = 0; lat = 1;
        #1 Clr_n = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_wait();
        test_flush_ack();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
